// File: rtl/apb_reg_slave.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : apb_reg_slave
// Description : APB register slave with word registers, a read-only status
//               register, programmable wait states and a write-strobe output.
// Revision    : 1.0
// ============================================================================
module apb_reg_slave #(
    parameter int AMBA_WORD       = 16,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int NUM_REGS        = 4,
    parameter int WAIT_STATES     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
    input  logic [AMBA_WORD-1:0]          PWDATA,
    output logic [AMBA_WORD-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [AMBA_WORD-1:0]          STATUS_IN,
    output logic [NUM_REGS*AMBA_WORD-1:0] REG_OUT,
    output logic                          REG_ENABLE,
    output logic [3:0]                    REG_WR_IDX
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SETUP      = 2'd1;
    localparam logic [1:0] ACCESS     = 2'd2;
    localparam logic [3:0] STATUS_IDX = 4'(NUM_REGS - 1);
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
    localparam logic [2:0] WAIT_LIMIT = 3'(WAIT_STATES);

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [2:0]           wait_cnt;
    logic [3:0]           idx;
    logic                 addr_err;
    logic                 complete;
    logic                 wr_ok;
    logic [AMBA_WORD-1:0] rd_mux;
    logic                 unused_addr_bits;

    assign idx              = PADDR[5:2];
    assign unused_addr_bits = ^PADDR[AMBA_ADDR_WIDTH-1:6];
    assign addr_err         = (PADDR[1:0] != 2'b00)
                            || ({1'b0, idx} >= NUM_REGS_W)
                            || (PWRITE && (idx == STATUS_IDX));
    assign complete         = PSEL && PENABLE && PREADY;
    assign wr_ok            = complete && PWRITE && !addr_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (PSEL && PENABLE) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    next_state = IDLE;
                end else if (PREADY) begin
                    next_state = PENABLE ? IDLE : SETUP;
                end else begin
                    next_state = ACCESS;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        PREADY  = (state == ACCESS) && (wait_cnt == WAIT_LIMIT);
        PSLVERR = PREADY && addr_err;
        PRDATA  = '0;
        if (PREADY && !PWRITE && !addr_err) begin
            PRDATA = (idx == STATUS_IDX) ? STATUS_IN : rd_mux;
        end
    end

    // Counter saturates naturally: PREADY rises once it reaches WAIT_LIMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 3'd0;
        end else if (next_state == SETUP) begin
            wait_cnt <= 3'd0;
        end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            REG_ENABLE <= 1'b0;
            REG_WR_IDX <= 4'd0;
        end else begin
            REG_ENABLE <= wr_ok;
            if (wr_ok) begin
                REG_WR_IDX <= idx;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_regs
            logic [AMBA_WORD-1:0] q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (wr_ok && (idx == 4'(g))) begin
                    q <= PWDATA;
                end
            end

            assign REG_OUT[g*AMBA_WORD +: AMBA_WORD] = q;
        end
    endgenerate

    assign REG_OUT[(NUM_REGS-1)*AMBA_WORD +: AMBA_WORD] = '0;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (idx == 4'(i)) begin
                rd_mux = REG_OUT[i*AMBA_WORD +: AMBA_WORD];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_apb_reg_slave
// Description : Self-checking bench for apb_reg_slave (WAIT_STATES 0, 3, 2).
// Revision    : 1.0
// ============================================================================
module tb_apb_reg_slave;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int NV = 18;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] status;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       psel;
    logic             penable;
    logic             pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic [DW-1:0]    status_in;
    logic [DW-1:0]    prdata     [3];
    logic             pready     [3];
    logic             pslverr    [3];
    logic [NR*DW-1:0] reg_out    [3];
    logic             reg_enable [3];
    logic [3:0]       reg_wr_idx [3];

    int               checks   = 0;
    int               failures = 0;
    vec_t             vecs [NV];
    resp_t            sb_q [$];
    resp_t            sb_e;
    resp_t            sb_push;
    int               en_pulses;
    int               en_cycles;
    logic             en_prev = 1'b0;

    logic [DW-1:0]    rd;
    logic             er;
    int               waits;
    logic             ok_wr;
    logic [3:0]       vidx;
    logic [3:0]       last_idx;
    logic [DW-1:0]    model [NR];
    logic             seen_bad;
    int               guard;

    always #5 clk = ~clk;

    apb_reg_slave #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0]), .STATUS_IN(status_in), .REG_OUT(reg_out[0]),
        .REG_ENABLE(reg_enable[0]), .REG_WR_IDX(reg_wr_idx[0])
    );

    apb_reg_slave #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1]), .STATUS_IN(status_in), .REG_OUT(reg_out[1]),
        .REG_ENABLE(reg_enable[1]), .REG_WR_IDX(reg_wr_idx[1])
    );

    apb_reg_slave #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2]), .STATUS_IN(status_in), .REG_OUT(reg_out[2]),
        .REG_ENABLE(reg_enable[2]), .REG_WR_IDX(reg_wr_idx[2])
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard for dut0: every completing transfer pops one expected response.
    always @(negedge clk) begin
        if (reset && psel[0] && penable && pready[0]) begin
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=completion required=none");
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_prdata", 64'(prdata[0]), 64'(sb_e.rdata));
                chk("sb_pslverr", 64'(pslverr[0]), 64'(sb_e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (reg_enable[0]) en_cycles++;
        if (reg_enable[0] && !en_prev) en_pulses++;
        en_prev = reg_enable[0];
    end

    task automatic push_exp(input logic [DW-1:0] r, input logic e);
        sb_push.rdata = r;
        sb_push.err   = e;
        sb_q.push_back(sb_push);
    endtask

    task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic keep,
                            output logic [DW-1:0] rdata, output logic err, output int nwait);
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        nwait   = 0;
        forever begin
            @(negedge clk);
            if (pready[d]) break;
            nwait++;
            if (nwait > 20) begin
                failures++;
                $display("FAIL xfer_timeout actual=no_pready required=pready dut=%0d", d);
                break;
            end
        end
        rdata = prdata[d];
        err   = pslverr[d];
        @(posedge clk); #1;
        penable = 1'b0;
        if (!keep) psel[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 20'h00004, 16'hA5C3, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 20'h00004, 16'h0000, 16'h0000, 16'hA5C3, 1'b0};
        vecs[2]  = '{1'b1, 20'h00000, 16'h1111, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 20'h00008, 16'hBEEF, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 20'h00000, 16'h0000, 16'h0000, 16'h1111, 1'b0};
        vecs[5]  = '{1'b0, 20'h00008, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
        vecs[6]  = '{1'b1, 20'h00010, 16'hDEAD, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 20'h00002, 16'hDEAD, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{1'b1, 20'h0000C, 16'hDEAD, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 20'h0000C, 16'h0000, 16'h1234, 16'h1234, 1'b0};
        vecs[10] = '{1'b0, 20'h00010, 16'h0000, 16'h1234, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 20'h00005, 16'h0000, 16'h1234, 16'h0000, 1'b1};
        vecs[12] = '{1'b1, 20'hF0004, 16'h5A5A, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 20'h00004, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
        vecs[14] = '{1'b0, 20'h0003C, 16'h0000, 16'hFFFF, 16'h0000, 1'b1};
        vecs[15] = '{1'b0, 20'hFFF4C, 16'h0000, 16'hCAFE, 16'hCAFE, 1'b0};
        vecs[16] = '{1'b1, 20'h80008, 16'h0F0F, 16'h0000, 16'h0000, 1'b0};
        vecs[17] = '{1'b0, 20'h00001, 16'h0000, 16'h1234, 16'h0000, 1'b1};

        for (int i = 0; i < NR; i++) model[i] = '0;
        last_idx  = 4'd0;
        reset     = 1'b0;
        psel      = 3'b000;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        status_in = 16'h7E57;

        // Reset state, held across clock edges with a setup request pending.
        #3;
        psel[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        psel[0] = 1'b0;
        chk("rst_pready", 64'(pready[0]), 64'd0);
        chk("rst_pslverr", 64'(pslverr[0]), 64'd0);
        chk("rst_prdata", 64'(prdata[0]), 64'd0);
        chk("rst_reg_out", reg_out[0], 64'd0);
        chk("rst_reg_enable", 64'(reg_enable[0]), 64'd0);
        chk("rst_reg_wr_idx", 64'(reg_wr_idx[0]), 64'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven single transfers on the zero-wait instance.
        for (int i = 0; i < NV; i++) begin
            status_in = vecs[i].status;
            push_exp(vecs[i].exp_rdata, vecs[i].exp_err);
            apb_xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, waits);
            chk("vec_waits", 64'(waits), 64'd1);
            ok_wr = vecs[i].wr && !vecs[i].exp_err;
            vidx  = vecs[i].addr[5:2];
            if (ok_wr) begin
                model[vidx[1:0]] = vecs[i].wdata;
                last_idx = vidx;
            end
            chk("vec_reg_out", reg_out[0], {16'h0000, model[2], model[1], model[0]});
            chk("vec_reg_enable", 64'(reg_enable[0]), 64'(ok_wr));
            chk("vec_reg_wr_idx", 64'(reg_wr_idx[0]), 64'(last_idx));
            @(posedge clk); #1;
            chk("vec_enable_drop", 64'(reg_enable[0]), 64'd0);
        end

        // Three wait states: write then read register 1.
        apb_xfer(1, 1'b1, 20'h00004, 16'hA5C3, 1'b0, rd, er, waits);
        chk("ws3_wr_waits", 64'(waits), 64'd4);
        chk("ws3_wr_err", 64'(er), 64'd0);
        chk("ws3_reg1", 64'(reg_out[1][31:16]), 64'hA5C3);
        apb_xfer(1, 1'b0, 20'h00004, 16'h0000, 1'b0, rd, er, waits);
        chk("ws3_rd_waits", 64'(waits), 64'd4);
        chk("ws3_rd_data", 64'(rd), 64'hA5C3);
        chk("ws3_rd_err", 64'(er), 64'd0);

        // Two wait states: abort after one ACCESS cycle.
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00008; pwdata = 16'h7777;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel[2] = 1'b0; penable = 1'b0;
        seen_bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pready[2] || pslverr[2] || reg_enable[2]) seen_bad = 1'b1;
        end
        chk("abort_no_ready_or_strobe", 64'(seen_bad), 64'd0);
        chk("abort_reg2", 64'(reg_out[2][47:32]), 64'd0);
        @(posedge clk); #1;
        apb_xfer(2, 1'b1, 20'h00008, 16'h3C3C, 1'b0, rd, er, waits);
        chk("ws2_after_abort_waits", 64'(waits), 64'd3);
        chk("ws2_after_abort_reg2", 64'(reg_out[2][47:32]), 64'h3C3C);

        // Back-to-back writes on the zero-wait instance.
        @(posedge clk); #1;
        en_pulses = 0;
        en_cycles = 0;
        push_exp(16'h0000, 1'b0);
        push_exp(16'h0000, 1'b0);
        apb_xfer(0, 1'b1, 20'h00000, 16'h1357, 1'b1, rd, er, waits);
        apb_xfer(0, 1'b1, 20'h00004, 16'h2468, 1'b0, rd, er, waits);
        repeat (3) @(posedge clk);
        #1;
        model[0] = 16'h1357;
        model[1] = 16'h2468;
        chk("b2b_pulses", 64'(en_pulses), 64'd2);
        chk("b2b_cycles", 64'(en_cycles), 64'd2);
        chk("b2b_reg_out", reg_out[0], {16'h0000, model[2], model[1], model[0]});
        chk("b2b_wr_idx", 64'(reg_wr_idx[0]), 64'd1);

        // Asynchronous reset 0.3 ns after the edge that raises PREADY.
        status_in = 16'h0000;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 20'h00004;
        @(posedge clk); #1;
        penable = 1'b1;
        guard = 0;
        forever begin
            @(posedge clk); #0.3;
            if (pready[1]) break;
            guard++;
            if (guard > 10) begin
                failures++;
                $display("FAIL rst_mid_timeout actual=no_pready required=pready");
                break;
            end
        end
        chk("pre_rst_prdata", 64'(prdata[1]), 64'hA5C3);
        reset = 1'b0;
        #0.3;
        chk("mid_rst_pready", 64'(pready[1]), 64'd0);
        chk("mid_rst_prdata", 64'(prdata[1]), 64'd0);
        chk("mid_rst_pslverr", 64'(pslverr[1]), 64'd0);
        chk("mid_rst_reg_out0", reg_out[0], 64'd0);
        chk("mid_rst_reg_out1", reg_out[1], 64'd0);
        chk("mid_rst_wr_idx", 64'(reg_wr_idx[0]), 64'd0);
        psel[1] = 1'b0; penable = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        push_exp(16'h0000, 1'b0);
        apb_xfer(0, 1'b1, 20'h00004, 16'hFACE, 1'b0, rd, er, waits);
        chk("post_rst_waits", 64'(waits), 64'd1);
        chk("post_rst_reg_out", reg_out[0], {16'h0000, 16'h0000, 16'hFACE, 16'h0000});
        chk("post_rst_enable", 64'(reg_enable[0]), 64'd1);
        chk("post_rst_wr_idx", 64'(reg_wr_idx[0]), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
